// File: rtl/clock_pkg.sv
// Shared encodings and field widths for the clock time-set logic.
package clock_pkg;

    localparam int unsigned HOURS_W = 5;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned SEC_W   = 6;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_SET_H  = 2'b01,
        ST_SET_M  = 2'b10,
        ST_COMMIT = 2'b11
    } set_state_e;

endpackage

// File: rtl/clock_set_ctrl_btn_press_detect.sv
// Rising-edge detector for one debounced button level.
module btn_press_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_c
);

    logic btn_q;

    // Remember last cycle's button level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    // A press is the first cycle the button reads high
    assign press_c = btn & ~btn_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set sequencer: RUN -> SET_H -> SET_M -> COMMIT, with idle-timeout abort.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned HOURS_MAX     = 23,
    parameter int unsigned MINUTES_MAX   = 59
) (
    input  logic               Clk_1sec,
    input  logic               reset,
    input  logic               mode_btn,
    input  logic               inc_btn,
    input  logic [HOURS_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]   cur_minutes,
    output logic               run_en,
    output logic               load,
    output logic [HOURS_W-1:0] load_hours,
    output logic [MIN_W-1:0]   load_minutes,
    output logic [SEC_W-1:0]   load_seconds,
    output logic [1:0]         set_state,
    output logic               blink,
    output logic               aborted
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);
    localparam logic [HOURS_W-1:0] H_LAST = HOURS_W'(HOURS_MAX);
    localparam logic [MIN_W-1:0]   M_LAST = MIN_W'(MINUTES_MAX);

    logic mode_press_c;
    logic inc_press_c;

    set_state_e         state_q,   state_d;
    logic [HOURS_W-1:0] shadow_h_q, shadow_h_d;
    logic [MIN_W-1:0]   shadow_m_q, shadow_m_d;
    logic [IDLE_W-1:0]  idle_q,    idle_d;
    logic               abort_d;
    logic               run_en_d;
    logic               load_d;
    logic               blink_d;

    btn_press_detect u_mode_press (
        .clk     (Clk_1sec),
        .rst     (reset),
        .btn     (mode_btn),
        .press_c (mode_press_c)
    );

    btn_press_detect u_inc_press (
        .clk     (Clk_1sec),
        .rst     (reset),
        .btn     (inc_btn),
        .press_c (inc_press_c)
    );

    // State, shadow, idle counter and output registers
    always_ff @(posedge Clk_1sec or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            shadow_h_q   <= '0;
            shadow_m_q   <= '0;
            idle_q       <= '0;
            run_en       <= 1'b1;
            load         <= 1'b0;
            load_seconds <= '0;
            blink        <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_h_q   <= shadow_h_d;
            shadow_m_q   <= shadow_m_d;
            idle_q       <= idle_d;
            run_en       <= run_en_d;
            load         <= load_d;
            load_seconds <= '0;
            blink        <= blink_d;
            aborted      <= abort_d;
        end
    end

    // Next state, shadow edits, timeout and next output values; MODE beats INC
    always_comb begin
        state_d    = state_q;
        shadow_h_d = shadow_h_q;
        shadow_m_d = shadow_m_q;
        idle_d     = '0;
        abort_d    = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (mode_press_c) begin
                    state_d    = ST_SET_H;
                    shadow_h_d = cur_hours;
                    shadow_m_d = cur_minutes;
                end
            end
            ST_SET_H: begin
                if (mode_press_c) begin
                    state_d = ST_SET_M;
                end else if (inc_press_c) begin
                    shadow_h_d = (shadow_h_q == H_LAST) ? '0 : shadow_h_q + HOURS_W'(1);
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_RUN;
                    abort_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            ST_SET_M: begin
                if (mode_press_c) begin
                    state_d = ST_COMMIT;
                end else if (inc_press_c) begin
                    shadow_m_d = (shadow_m_q == M_LAST) ? '0 : shadow_m_q + MIN_W'(1);
                end else if (idle_q == IDLE_LAST) begin
                    state_d = ST_RUN;
                    abort_d = 1'b1;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        run_en_d = (state_d == ST_RUN);
        load_d   = (state_d == ST_COMMIT);
        blink_d  = ((state_d == ST_SET_H) || (state_d == ST_SET_M)) ? ~blink : 1'b0;
    end

    assign set_state    = state_q;
    assign load_hours   = shadow_h_q;
    assign load_minutes = shadow_m_q;

endmodule
